// File: rtl/screen_dump_tx_pkg.sv
// screen_dump_tx_pkg: shared constants, FSM encoding and character filter for the screen dump path
package screen_dump_tx_pkg;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam int TEXT_ROWS = 4;
  localparam int TEXT_COLS = 32;
  localparam int FRAME_BITS = 10;
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WAIT, S_LOAD, S_SEND, S_CR, S_LF, S_DONE
  } state_t;
  function automatic logic [7:0] map_char(input logic [7:0] b);
    return (b >= 8'h20 && b <= 8'h7E) ? b : ASCII_SP;
  endfunction
endpackage

// File: rtl/screen_dump_tx_uart.sv
// uart_tx_8n1: 8N1 serial transmitter with one setup cycle between acceptance and the start bit
module uart_tx_8n1 import screen_dump_tx_pkg::*; #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_FREE = TW'(CLKS_PER_BIT - 2);
  logic [TW-1:0] tmr_q, tmr_d;
  logic [9:0] sh_q, sh_d;
  logic [3:0] bit_q, bit_d;
  logic tx_q, tx_d, busy_q, busy_d;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr_q  <= '0;
      sh_q   <= '1;
      bit_q  <= '0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      tmr_q  <= tmr_d;
      sh_q   <= sh_d;
      bit_q  <= bit_d;
      tx_q   <= tx_d;
      busy_q <= busy_d;
    end
  end
  // Busy drops one cycle before the stop bit ends: the next frame's setup cycle completes it.
  always_comb begin
    tmr_d  = tmr_q;
    sh_d   = sh_q;
    bit_d  = bit_q;
    tx_d   = tx_q;
    busy_d = busy_q;
    if (!busy_q) begin
      if (tx_start) begin
        busy_d = 1'b1;
        sh_d   = {1'b1, tx_data, 1'b0};
        tmr_d  = T_LAST;
        bit_d  = '0;
      end
    end else if (tmr_q == T_LAST) begin
      tx_d  = sh_q[0];
      sh_d  = {1'b1, sh_q[9:1]};
      tmr_d = '0;
      bit_d = bit_q + 4'd1;
    end else begin
      tmr_d  = tmr_q + 1'b1;
      busy_d = !(bit_q == 4'(FRAME_BITS) && tmr_q == T_FREE);
    end
  end
  assign tx      = tx_q;
  assign tx_busy = busy_q;
endmodule

// File: rtl/screen_dump_tx.sv
// screen_dump_tx: streams the 4x32 text RAM row by row over 8N1 UART with CR LF after each row
module screen_dump_tx import screen_dump_tx_pkg::*; #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int COL_START    = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic [1:0] rd_row,
  output logic [4:0] rd_col,
  input  logic [7:0] rd_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  localparam logic [4:0] COL0     = 5'(COL_START);
  localparam logic [4:0] COL_LAST = 5'(COL_START - 1);
  state_t state_q, state_d, sent_q, sent_d;
  logic [1:0] row_q, row_d;
  logic [4:0] col_q, col_d;
  logic tx_start, tx_busy;
  logic [7:0] tx_data;
  uart_tx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk      (clk),
    .reset_n  (reset_n),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx       (tx),
    .tx_busy  (tx_busy)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sent_q  <= S_LOAD;
      row_q   <= '0;
      col_q   <= COL0;
    end else begin
      state_q <= state_d;
      sent_q  <= sent_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end
  // sent_q remembers what the UART is carrying so SEND knows where to go next.
  always_comb begin
    state_d  = state_q;
    sent_d   = sent_q;
    row_d    = row_q;
    col_d    = col_q;
    tx_start = 1'b0;
    tx_data  = ASCII_SP;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_ADDR;
        row_d   = '0;
        col_d   = COL0;
      end
      S_ADDR: state_d = S_WAIT;
      S_WAIT: state_d = S_LOAD;
      S_LOAD, S_CR, S_LF: begin
        tx_start = 1'b1;
        tx_data  = state_q == S_CR ? ASCII_CR : state_q == S_LF ? ASCII_LF : map_char(rd_data);
        if (!tx_busy) begin
          sent_d  = state_q;
          state_d = S_SEND;
        end
      end
      S_SEND: if (!tx_busy) begin
        state_d = sent_q == S_CR ? S_LF
                : sent_q == S_LF ? (row_q == 2'(TEXT_ROWS - 1) ? S_DONE : S_ADDR)
                : col_q == COL_LAST ? S_CR : S_ADDR;
        if (sent_q == S_LOAD) col_d = col_q + 5'd1;
        if (sent_q == S_LF) begin
          row_d = row_q + 2'd1;
          col_d = COL0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        row_d   = '0;
        col_d   = COL0;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign rd_row = row_q;
  assign rd_col = col_q;
  assign busy   = state_q != S_IDLE;
  assign done   = state_q == S_DONE;
endmodule
